guitar_input_conditioner: RTL and testbench
===========================================

# guitar_input_conditioner

Conditions the raw guitar-controller GPIO lines (five fret buttons, one strum bar) into clean fret levels and discrete strum events. Each accepted strum produces one event carrying the fret chord held at that instant, delivered to `gameplay` over a valid/ready handshake with a one-entry holding register. It sits between the GPIO pins and `gameplay`, replacing the direct `GPIO_0` wiring.

## Interface
- `DEBOUNCE_CYCLES`, 500000, consecutive stable cycles required before a debounced level changes (10 ms at 50 MHz); must be ≥1.
- `STRUM_ACTIVE_LOW`, 1, selects the pressed level of `strum_raw`: 1 means pressed = 0, 0 means pressed = 1. Frets are always active-high.
- `clk`  in  1  system clock, CLOCK_50 domain.
- `reset_n`  in  1  reset; **synchronous, active-low**.
- `pause`  in  1  high: new strum events are discarded.
- `fret_raw`  in  5  asynchronous fret buttons (GPIO_0[5:1]).
- `strum_raw`  in  1  asynchronous strum bar (GPIO_0[0]).
- `frets`  out  5  debounced fret levels, 1 = held.
- `ev_valid`  out  1  strum event pending.
- `ev_ready`  in  1  consumer accepts the event this cycle.
- `ev_chord`  out  5  fret chord captured with the event; stable while `ev_valid`.
- `overrun_cnt`  out  8  saturating count of events dropped because the holding register was full.

## Operation
- Synchronizer: two flops per raw input. On reset, each flop loads its inactive level: 0 for frets, `STRUM_ACTIVE_LOW` for strum.
- Debouncer, one per input: counter width $clog2(DEBOUNCE_CYCLES+1).
  - While synced ≠ stable, the counter increments.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the mismatch still present, stable takes the synced value on the next edge and the counter clears.
  - Any cycle with synced = stable clears the counter.
- Strum is normalised after debouncing: `strum_press = stable ^ STRUM_ACTIVE_LOW` (1 = pressed).
- Strum edge: a cycle in which `strum_press` goes 0→1, detected with one registered copy.
- Event FSM states:
  - EMPTY → FULL on a strum edge with `pause` low. `ev_chord` loads the `frets` value of that same cycle.
  - FULL → EMPTY on `ev_ready` with no strum edge.
  - FULL stays FULL when `ev_ready` and an accepted strum edge coincide; the new chord is loaded (back-to-back, no bubble).
  - FULL with a strum edge and `ev_ready` low: the new event is dropped, the held event is kept, and `overrun_cnt` increments, saturating at 255.
- Pause: strum edges while `pause` is high are ignored and not counted as overruns. A pending event stays pending and can still be consumed.
- `ev_ready` while EMPTY has no effect.
- Reset values: `frets`=0, `ev_valid`=0, `ev_chord`=0, `overrun_cnt`=0, counters 0, FSM EMPTY. Reset mid-operation discards any pending event and any debounce in progress.

## Timing
- Raw change at edge N becomes synced at N+2 and stable (`frets` changes) at N+2+DEBOUNCE_CYCLES, provided the input holds.
- The strum edge is seen one cycle after the stable strum changes. `ev_valid` rises on the following edge, so total strum latency is N+4+DEBOUNCE_CYCLES.
- A fret and the strum changing on the same raw edge produce the new chord in `ev_chord`, because both debounce in lockstep.
- Handshake: a transfer occurs on any edge with `ev_valid & ev_ready`. `ev_valid` and `ev_chord` depend only on registers. `ev_ready` may combinationally depend on `ev_valid`.
- Glitches shorter than DEBOUNCE_CYCLES cycles after synchronization never reach `frets`.

## Configuration
- `GUITAR_STRUM_BOTH_EDGES_EN` defined: a strum edge is either transition of `strum_press` (0→1 or 1→0), matching an up/down strum bar. Each transition yields one event.
- Not defined: only 0→1 generates an event; the release transition is ignored.

## Structure
- Shared package `guitar_pkg`:
  - `NUM_FRETS` = 5.
  - `fret_t` (5-bit chord type).
  - Event FSM state enum `ev_state_t` {EV_EMPTY, EV_FULL}.
- Sub-module `input_debounce`: single-bit 2-flop synchronizer plus debounce counter.
  - Parameters DEBOUNCE_CYCLES and RESET_LEVEL.
  - Ports clk, reset_n, raw, stable.
  - Instantiated six times.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and STRUM_ACTIVE_LOW=1.
- Fret 2 raw pulse high for 3 cycles → `frets` stays 00000. Held for 10 cycles → `frets`=00100 exactly 6 cycles after the raw rise.
- Frets=10010 held, then `strum_raw` 1→0 held, `ev_ready`=0 → `ev_valid`=1 at raw edge +8 with `ev_chord`=10010. Then `ev_ready`=1 for one cycle → `ev_valid`=0.
- Event pending, `ev_ready`=0, three further strums → `ev_chord` unchanged and `overrun_cnt`=3. Forcing 300 overruns → `overrun_cnt`=255.
- `ev_ready`=1 on the same cycle a new strum edge arrives → `ev_valid` stays 1, `ev_chord` takes the new chord, `overrun_cnt` unchanged.
- `pause`=1 during a strum → no event and no overrun. Pending event from before the pause is still consumed on `ev_ready`.
- `reset_n`=0 for one cycle while `ev_valid`=1 and a debounce count is mid-way → next cycle all outputs 0. Strum release/press with and without `GUITAR_STRUM_BOTH_EDGES_EN` → 2 events versus 1.

Source files
------------

// File: rtl/guitar_pkg.sv
// guitar_pkg: shared fret count, chord type and event FSM states for the guitar input path
package guitar_pkg;
    localparam int NUM_FRETS = 5;
    typedef logic [NUM_FRETS-1:0] fret_t;
    typedef enum logic {EV_EMPTY, EV_FULL} ev_state_t;
endpackage

// File: rtl/guitar_input_debounce.sv
// input_debounce: 2-flop synchronizer plus stable-count debouncer for one raw line
//   ports: clk, reset_n (sync, active-low), raw (async in), stable (debounced level)
module input_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic raw,
    output logic stable
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          s1, s2;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1     <= RESET_LEVEL;
            s2     <= RESET_LEVEL;
            stable <= RESET_LEVEL;
            cnt    <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable <= s2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end
endmodule

// File: rtl/guitar_input_conditioner.sv
// guitar_input_conditioner: debounces fret/strum GPIO and emits strum events with the held chord
//   ports: clk, reset_n (sync, active-low), pause, fret_raw[5], strum_raw -> frets[5];
//          ev_valid/ev_ready/ev_chord[5] event handshake (one-entry holding register);
//          overrun_cnt[8] saturating count of events dropped while the register was full
//   GUITAR_STRUM_BOTH_EDGES_EN: when defined, press and release of the strum bar each yield an event
module guitar_input_conditioner
    import guitar_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = 500000,
    parameter bit STRUM_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pause,
    input  fret_t      fret_raw,
    input  logic       strum_raw,
    output fret_t      frets,
    output logic       ev_valid,
    input  logic       ev_ready,
    output fret_t      ev_chord,
    output logic [7:0] overrun_cnt
);
    logic      strum_stable, strum_press, press_q, edge_now, strum_edge, accept;
    ev_state_t state, state_nx;
    for (genvar i = 0; i < NUM_FRETS; i++) begin : g_fret
        input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(1'b0)) u_fret (
            .clk    (clk),
            .reset_n(reset_n),
            .raw    (fret_raw[i]),
            .stable (frets[i])
        );
    end
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .RESET_LEVEL(STRUM_ACTIVE_LOW)) u_strum (
        .clk    (clk),
        .reset_n(reset_n),
        .raw    (strum_raw),
        .stable (strum_stable)
    );
    assign strum_press = strum_stable ^ STRUM_ACTIVE_LOW;
`ifdef GUITAR_STRUM_BOTH_EDGES_EN
    assign edge_now = strum_press ^ press_q;
`else
    assign edge_now = strum_press & ~press_q;
`endif
    // The edge is registered so it lines up with frets, which debounce in lockstep with strum.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            press_q    <= 1'b0;
            strum_edge <= 1'b0;
        end else begin
            press_q    <= strum_press;
            strum_edge <= edge_now;
        end
    end
    assign accept = strum_edge & ~pause;
    always_ff @(posedge clk) begin
        if (!reset_n) state <= EV_EMPTY;
        else          state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        if (state == EV_EMPTY) state_nx = accept ? EV_FULL : EV_EMPTY;
        else                   state_nx = (ev_ready & ~accept) ? EV_EMPTY : EV_FULL;
    end
    always_comb begin
        ev_valid = (state == EV_FULL);
    end
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ev_chord    <= '0;
            overrun_cnt <= '0;
        end else begin
            if (accept & (~ev_valid | ev_ready)) ev_chord <= frets;
            if (accept & ev_valid & ~ev_ready & (overrun_cnt != 8'hFF)) overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_guitar_input_conditioner.sv
// tb_guitar_input_conditioner: scoreboard bench for the guitar input conditioner (DEBOUNCE_CYCLES=4)
module tb_guitar_input_conditioner;
`ifdef GUITAR_STRUM_BOTH_EDGES_EN
    localparam bit BOTH = 1'b1;
`else
    localparam bit BOTH = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       pause = 1'b0;
    logic [4:0] fret_raw = '0;
    logic       strum_raw = 1'b1;
    logic [4:0] frets;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [4:0] ev_chord;
    logic [7:0] overrun_cnt;
    int         vectors = 0;
    int         miscompares = 0;
    int         xfers = 0;
    logic [4:0] sb[$];

    guitar_input_conditioner #(.DEBOUNCE_CYCLES(4), .STRUM_ACTIVE_LOW(1'b1)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pause      (pause),
        .fret_raw   (fret_raw),
        .strum_raw  (strum_raw),
        .frets      (frets),
        .ev_valid   (ev_valid),
        .ev_ready   (ev_ready),
        .ev_chord   (ev_chord),
        .overrun_cnt(overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        ev_ready  = 1'b0;
        pause     = 1'b0;
        fret_raw  = '0;
        strum_raw = 1'b1;
        tick(2);
        reset_n = 1'b1;
        sb.delete();
    endtask

    task automatic set_frets(input logic [4:0] f);
        fret_raw = f;
        tick(6);
    endtask

    // One call yields exactly one strum transition that generates an event in either build.
    task automatic strum_start(input logic [4:0] ch, input bit expect_ev);
        strum_raw = BOTH ? ~strum_raw : 1'b0;
        if (expect_ev) sb.push_back(ch);
    endtask

    task automatic strum_finish();
        if (!BOTH) begin
            strum_raw = 1'b1;
            tick(8);
        end
    endtask

    task automatic ready_pulse();
        ev_ready = 1'b1;
        tick(1);
        ev_ready = 1'b0;
    endtask

    always @(negedge clk) begin
        #2;
        if (reset_n && ev_valid && ev_ready) begin
            xfers++;
            if (sb.size() == 0) check("unexpected_event", 32'(ev_chord), 32'h1f);
            else check("sb_chord", 32'(ev_chord), 32'(sb.pop_front()));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        do_reset();
        check("rst_frets", 32'(frets), 32'h0);
        check("rst_valid", 32'(ev_valid), 32'h0);
        check("rst_chord", 32'(ev_chord), 32'h0);
        check("rst_overrun", 32'(overrun_cnt), 32'h0);

        fret_raw = 5'b00100;
        tick(3);
        fret_raw = 5'b00000;
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("glitch_frets", 32'(frets), 32'h0);
        end
        fret_raw = 5'b00100;
        tick(5);
        check("fret_early", 32'(frets), 32'h0);
        tick(1);
        check("fret_at6", 32'(frets), 32'h04);

        set_frets(5'b10010);
        check("chord_frets", 32'(frets), 32'h12);
        strum_start(5'b10010, 1'b1);
        tick(7);
        check("strum_early", 32'(ev_valid), 32'h0);
        tick(1);
        check("strum_at8", 32'(ev_valid), 32'h1);
        check("strum_chord", 32'(ev_chord), 32'h12);
        ready_pulse();
        check("consumed", 32'(ev_valid), 32'h0);
        strum_finish();

        set_frets(5'b00001);
        strum_start(5'b00001, 1'b1);
        tick(8);
        strum_finish();
        set_frets(5'b11000);
        for (int i = 0; i < 3; i++) begin
            strum_start(5'b11000, 1'b0);
            tick(8);
            strum_finish();
        end
        check("ovr_chord", 32'(ev_chord), 32'h01);
        check("ovr_cnt3", 32'(overrun_cnt), 32'd3);
        for (int i = 0; i < 297; i++) begin
            strum_start(5'b11000, 1'b0);
            tick(8);
            strum_finish();
        end
        check("ovr_sat", 32'(overrun_cnt), 32'd255);
        check("ovr_valid", 32'(ev_valid), 32'h1);
        ready_pulse();
        check("ovr_drained", 32'(ev_valid), 32'h0);

        do_reset();
        check("ovr_cleared", 32'(overrun_cnt), 32'h0);
        set_frets(5'b00011);
        strum_start(5'b00011, 1'b1);
        tick(8);
        strum_finish();
        set_frets(5'b01100);
        strum_start(5'b01100, 1'b1);
        tick(7);
        ready_pulse();
        check("b2b_valid", 32'(ev_valid), 32'h1);
        check("b2b_chord", 32'(ev_chord), 32'h0c);
        check("b2b_overrun", 32'(overrun_cnt), 32'h0);
        ready_pulse();
        check("b2b_drained", 32'(ev_valid), 32'h0);
        strum_finish();

        pause = 1'b1;
        strum_start(5'b01100, 1'b0);
        tick(8);
        check("pause_empty", 32'(ev_valid), 32'h0);
        strum_finish();
        pause = 1'b0;
        set_frets(5'b00101);
        strum_start(5'b00101, 1'b1);
        tick(8);
        strum_finish();
        pause = 1'b1;
        set_frets(5'b11111);
        strum_start(5'b11111, 1'b0);
        tick(8);
        strum_finish();
        check("pause_overrun", 32'(overrun_cnt), 32'h0);
        check("pause_chord", 32'(ev_chord), 32'h05);
        check("pause_pending", 32'(ev_valid), 32'h1);
        ready_pulse();
        check("pause_drained", 32'(ev_valid), 32'h0);
        pause = 1'b0;

        set_frets(5'b00110);
        strum_start(5'b00110, 1'b1);
        tick(8);
        strum_finish();
        check("mid_pending", 32'(ev_valid), 32'h1);
        fret_raw = 5'b11001;
        tick(3);
        reset_n   = 1'b0;
        fret_raw  = '0;
        strum_raw = 1'b1;
        tick(1);
        sb.delete();
        check("mid_frets", 32'(frets), 32'h0);
        check("mid_valid", 32'(ev_valid), 32'h0);
        check("mid_chord", 32'(ev_chord), 32'h0);
        check("mid_overrun", 32'(overrun_cnt), 32'h0);
        reset_n = 1'b1;
        tick(8);
        check("mid_settled", 32'(frets), 32'h0);

        set_frets(5'b01010);
        xfers    = 0;
        ev_ready = 1'b1;
        strum_raw = 1'b0;
        sb.push_back(5'b01010);
        tick(10);
        strum_raw = 1'b1;
        if (BOTH) sb.push_back(5'b01010);
        tick(10);
        ev_ready = 1'b0;
        check("edge_events", 32'(xfers), BOTH ? 32'd2 : 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);
        tick(2);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
